rd_port_arbiter: RTL and testbench

- Shares one read port of a memory bank among NB_REQ read requesters, using valid/ready handshakes on both the request and response sides.
- Arbitration is round-robin; one RAM read is issued per cycle at most.
- Read data from the fixed-latency RAM is captured into a response FIFO, tagged with the requester index, then returned to the issuing requester in order.
- Credit control on the FIFO guarantees RAM data is never dropped, since the RAM read port has no backpressure.

---
 rtl/rd_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_rd_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_port_arbiter.sv
// Generic synchronous FIFO with occupancy count; head entry is visible combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module rd_port_arbiter_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_vld_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + CNT_W'(push_vld_i) - CNT_W'(pop_vld_i);
    end

    always_ff @(posedge clk_i) begin
        if (push_vld_i) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_vld_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_vld_i) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign empty_o    = (count_q == '0);
    assign head_dat_o = mem_q[rd_q];
    assign count_o    = count_q;
endmodule

// Round-robin sharing of one fixed-latency RAM read port among NB_REQ requesters.
// Latency: accept at cycle T issues the read in T; response valid from T+RAM_LATENCY+1.
// Backpressure: credits cover in-flight reads plus queued responses, so RAM data is never dropped.
module rd_port_arbiter #(
    parameter int NB_REQ      = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int REQ_WIDTH   = $clog2(NB_REQ)
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NB_REQ-1:0]            req_valid,
    output logic [NB_REQ-1:0]            req_ready,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NB_REQ-1:0]            rsp_valid,
    input  logic [NB_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         ram_rden,
    output logic [ADDR_WIDTH-1:0]        ram_rdaddr,
    input  logic [DATA_WIDTH-1:0]        ram_rddata
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = REQ_WIDTH + DATA_WIDTH;

    logic [REQ_WIDTH-1:0]  rr_q;
    logic [REQ_WIDTH-1:0]  rr_d;
    logic [REQ_WIDTH-1:0]  gnt_idx;
    logic [NB_REQ-1:0]     grant;
    logic                  gnt_any;
    logic [CNT_W-1:0]      outst_q;
    logic [CNT_W-1:0]      outst_d;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic [ENT_W-1:0]      head;
    logic [REQ_WIDTH-1:0]  head_idx;
    logic                  tag_vld_q [RAM_LATENCY];
    logic [REQ_WIDTH-1:0]  tag_idx_q [RAM_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_a    [NB_REQ];

    function automatic logic [REQ_WIDTH-1:0] rot_idx(input logic [REQ_WIDTH-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NB_REQ) begin
            s = s - NB_REQ;
        end
        return REQ_WIDTH'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NB_REQ; i++) begin
            addr_a[i] = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        end
    end

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (!gnt_any && req_valid[rot_idx(rr_q, k)]) begin
                gnt_any                 = 1'b1;
                gnt_idx                 = rot_idx(rr_q, k);
                grant[rot_idx(rr_q, k)] = 1'b1;
            end
        end
    end

    // Reset gating keeps ready low while areset is held, independent of request inputs.
    assign credit_ok = !areset &&
        (((CNT_W+1)'(outst_q) + (CNT_W+1)'(fifo_cnt)) < (CNT_W+1)'(FIFO_DEPTH));
    assign req_ready  = grant & {NB_REQ{credit_ok}};
    assign issue      = gnt_any & credit_ok;
    assign ram_rden   = issue;
    assign ram_rdaddr = issue ? addr_a[gnt_idx] : '0;

    assign push     = tag_vld_q[RAM_LATENCY-1];
    assign head_idx = head[ENT_W-1 -: REQ_WIDTH];
    assign pop      = !fifo_empty && rsp_ready[head_idx];

    always_comb begin
        rr_d    = issue ? rot_idx(gnt_idx, 1) : rr_q;
        outst_d = outst_q + CNT_W'(issue) - CNT_W'(push);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_q    <= '0;
            outst_q <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            rr_q         <= rr_d;
            outst_q      <= outst_d;
            tag_vld_q[0] <= issue;
            tag_idx_q[0] <= gnt_idx;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    rd_port_arbiter_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk_i      (aclk),
        .rst_i      (areset),
        .push_vld_i (push),
        .push_dat_i ({tag_idx_q[RAM_LATENCY-1], ram_rddata}),
        .pop_vld_i  (pop),
        .empty_o    (fifo_empty),
        .head_dat_o (head),
        .count_o    (fifo_cnt)
    );

    always_comb begin
        rsp_valid = '0;
        if (!fifo_empty) begin
            rsp_valid[head_idx] = 1'b1;
        end
    end

    assign rsp_data = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_rd_port_arbiter.sv
// Bench for rd_port_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_rd_port_arbiter;
    localparam int NB = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int D  = 4;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NB-1:0]     req_valid;
    logic [NB-1:0]     req_ready;
    logic [NB*AW-1:0]  req_addr;
    logic [NB-1:0]     rsp_valid;
    logic [NB-1:0]     rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              ram_rden;
    logic [AW-1:0]     ram_rdaddr;
    logic [DW-1:0]     ram_rddata;

    int n_checks = 0;
    int n_err    = 0;

    always #5 aclk = ~aclk;

    rd_port_arbiter #(
        .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(L), .FIFO_DEPTH(D)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .ram_rden   (ram_rden),
        .ram_rdaddr (ram_rdaddr),
        .ram_rddata (ram_rddata)
    );

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {16'hA5A5, 8'h00, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural RAM: returns ram_word(addr) exactly L cycles after rden, noise otherwise.
    logic          hv [L];
    logic [AW-1:0] ha [L];
    logic [DW-1:0] garbage;
    always @(posedge aclk) begin
        hv[0] <= ram_rden;
        ha[0] <= ram_rdaddr;
        for (int i = 1; i < L; i++) begin
            hv[i] <= hv[i-1];
            ha[i] <= ha[i-1];
        end
        garbage <= $urandom;
    end
    assign ram_rddata = hv[L-1] ? ram_word(ha[L-1]) : garbage;

    // Reference model: every accepted read waits in one queue until popped.
    typedef struct {
        int          idx;
        logic [DW-1:0] data;
        int          c;
    } ent_t;
    ent_t mq[$];
    int   m_rr = 0;
    int   cyc  = 0;

    always @(negedge aclk) begin : cmp
        logic [NB-1:0] e_rdy;
        logic [NB-1:0] e_rv;
        logic [DW-1:0] e_dat;
        logic          e_rden;
        logic [AW-1:0] e_addr;
        int            g;
        bit            head_ok;
        ent_t          e;
        cyc++;
        e_rdy = '0; e_rv = '0; e_dat = '0; e_rden = 1'b0; e_addr = '0; g = -1; head_ok = 1'b0;
        if (areset) begin
            mq.delete();
            m_rr = 0;
        end else begin
            head_ok = (mq.size() > 0) && (mq[0].c + L + 1 <= cyc);
            if (head_ok) begin
                e_rv[mq[0].idx] = 1'b1;
                e_dat = mq[0].data;
            end
            if (mq.size() < D) begin
                for (int k = 0; k < NB; k++) begin
                    if (g < 0 && req_valid[(m_rr + k) % NB]) g = (m_rr + k) % NB;
                end
            end
            if (g >= 0) begin
                e_rdy[g] = 1'b1;
                e_rden   = 1'b1;
                e_addr   = req_addr[g*AW +: AW];
            end
        end
        check("model_req_ready", 64'(req_ready), 64'(e_rdy));
        check("model_rsp_valid", 64'(rsp_valid), 64'(e_rv));
        check("model_rsp_data", 64'(rsp_data), 64'(e_dat));
        check("model_ram_rden", 64'(ram_rden), 64'(e_rden));
        check("model_ram_rdaddr", 64'(ram_rdaddr), 64'(e_addr));
        if (!areset) begin
            if (head_ok && rsp_ready[mq[0].idx]) void'(mq.pop_front());
            if (g >= 0) begin
                e.idx  = g;
                e.data = ram_word(e_addr);
                e.c    = cyc;
                mq.push_back(e);
                m_rr = (g + 1) % NB;
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    int            acc;
    logic [NB-1:0] held_v;
    logic [DW-1:0] held_d;

    initial begin
        areset = 1'b1; req_valid = '1; req_addr = 32'h1515_1515; rsp_ready = '0;
        #2;
        check("reset_req_ready", 64'(req_ready), 64'h0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset_rsp_data", 64'(rsp_data), 64'h0);
        check("reset_ram_rden", 64'(ram_rden), 64'h0);
        check("reset_ram_rdaddr", 64'(ram_rdaddr), 64'h0);
        step(); step();
        areset = 1'b0; req_valid = '0;
        step();

        // Single request from requester 2
        req_valid = 4'b0100; req_addr = 32'h0015_0000;
        #1;
        check("single_rden", 64'(ram_rden), 64'h1);
        check("single_rdaddr", 64'(ram_rdaddr), 64'h15);
        check("single_ready", 64'(req_ready), 64'h4);
        step(); req_valid = '0; #1;
        check("single_lat1", 64'(rsp_valid), 64'h0);
        step(); #1;
        check("single_lat2", 64'(rsp_valid), 64'h0);
        step(); #1;
        check("single_rsp_valid", 64'(rsp_valid), 64'h4);
        check("single_rsp_data", 64'(rsp_data), 64'hA5A5_0015);
        step(); rsp_ready = 4'b0100; #1;
        check("single_hold", 64'(rsp_valid), 64'h4);
        step(); rsp_ready = '0; #1;
        check("single_popped", 64'(rsp_valid), 64'h0);

        // Round-robin, full rate, pointer starts at 3
        rsp_ready = '1;
        for (int k = 0; k < 12; k++) begin
            step(); req_valid = '1; req_addr = $urandom; #1;
            check("rr_grant", 64'(req_ready), 64'(4'b0001 << ((3 + k) % 4)));
        end
        step(); req_valid = '0;
        repeat (5) step();

        // Backpressure: exactly D accepts
        rsp_ready = '0; acc = 0;
        for (int k = 0; k < 12; k++) begin
            step(); req_valid = '1; req_addr = $urandom; #1;
            if (|(req_valid & req_ready)) acc++;
        end
        check("bp_accepts", 64'(acc), 64'd4);
        check("bp_blocked", 64'(req_ready), 64'h0);
        held_v = rsp_valid; held_d = rsp_data;
        step(); #1;
        check("bp_stable_valid", 64'(rsp_valid), 64'(held_v));
        check("bp_stable_data", 64'(rsp_data), 64'(held_d));
        step(); rsp_ready = '1; #1;
        check("bp_no_early_credit", 64'(req_ready), 64'h0);
        step(); #1;
        check("bp_credit_return", 64'(|req_ready), 64'h1);
        repeat (8) step();
        req_valid = '0;
        repeat (6) step();

        // Head-of-line blocking
        req_valid = 4'b0010; rsp_ready = 4'b1000;
        step(); req_valid = '0;
        repeat (5) step();
        #1;
        check("hol_blocked", 64'(rsp_valid), 64'h2);
        step(); rsp_ready = 4'b0010; #1;
        check("hol_release", 64'(rsp_valid), 64'h2);
        step(); rsp_ready = '0; #1;
        check("hol_popped", 64'(rsp_valid), 64'h0);

        // Pointer wrap 3 -> 0 -> pointer 1
        step(); req_valid = 4'b1000; #1;
        check("wrap_grant3", 64'(req_ready), 64'h8);
        step(); req_valid = 4'b0001; #1;
        check("wrap_grant0", 64'(req_ready), 64'h1);
        step(); req_valid = '1; rsp_ready = '1; #1;
        check("wrap_ptr1", 64'(req_ready), 64'h2);
        step(); req_valid = '0;
        repeat (6) step();

        // Reset with reads in flight
        rsp_ready = '0; req_valid = 4'b0101; req_addr = $urandom;
        step();
        step(); req_valid = '0; areset = 1'b1; #1;
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_mid_rsp_data", 64'(rsp_data), 64'h0);
        check("rst_mid_rden", 64'(ram_rden), 64'h0);
        step(); step(); areset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            check("rst_no_spurious", 64'(rsp_valid), 64'h0);
        end

        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            step();
            req_valid = NB'($urandom);
            req_addr  = $urandom;
            if ((k % 1000) < 500) rsp_ready = NB'($urandom);
            else rsp_ready = ($urandom_range(0, 7) != 0) ? '1 : NB'($urandom);
            areset = ($urandom_range(0, 299) == 0);
        end
        step(); areset = 1'b0; req_valid = '0; rsp_ready = '1;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
